// File: rtl/accumulate.sv
// accumulate: streaming IEEE-754 binary32 accumulator with a built-in
// single-cycle FP32 adder (unpack, align, add/sub, normalise, round, pack).
// start clears the running total to +0.0, valid adds data into it, and
// finished produces a registered done pulse one cycle later.
// Configuration macro: ACCUMULATE_RNE_EN
//   defined   -> round-to-nearest-even using guard/round/sticky bits
//   undefined -> round toward zero (guard/round/sticky truncated)
// Denormal operands are flushed to signed zero; denormal results to +0.0.

module accumulate (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        valid,
    input  logic [31:0] data,
    input  logic        finished,
    output logic [31:0] result,
    output logic        done
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic        done_q;
    logic        done_d;

    // Leading-zero count of a 27-bit significand; the highest set bit wins.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] lz;
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            lz = v[i] ? 5'(26 - i) : lz;
        end
        return lz;
    endfunction

    // Single-precision add with flush-to-zero and canonical NaN handling.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               sa, sb, sl, ss;
        logic [7:0]         ea, eb, el, es;
        logic [22:0]        fa, fb;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [23:0]        ml, ms;
        logic [7:0]         diff;
        logic [26:0]        ml_ext, ms_ext, ms_al, mask;
        logic               sticky;
        logic [27:0]        sum;
        logic [26:0]        norm;
        logic [4:0]         lz;
        logic signed [9:0]  exp_n;
        logic [24:0]        rnd;
        logic [22:0]        frac;
        logic               inc;
        logic [31:0]        res;

        sa     = a[31];
        ea     = a[30:23];
        fa     = a[22:0];
        sb     = b[31];
        eb     = b[30:23];
        fb     = b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        // Exponent zero covers both true zeros and flushed denormals.
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);

        sl     = 1'b0;
        ss     = 1'b0;
        el     = 8'd0;
        es     = 8'd0;
        ml     = 24'd0;
        ms     = 24'd0;
        diff   = 8'd0;
        ml_ext = 27'd0;
        ms_ext = 27'd0;
        ms_al  = 27'd0;
        mask   = 27'd0;
        sticky = 1'b0;
        sum    = 28'd0;
        norm   = 27'd0;
        lz     = 5'd0;
        exp_n  = 10'sd0;
        rnd    = 25'd0;
        frac   = 23'd0;
        inc    = 1'b0;
        res    = 32'd0;

        if (a_nan || b_nan) begin
            res = QNAN;
        end else if (a_inf && b_inf) begin
            res = (sa != sb) ? QNAN : a;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if (a_zero && b_zero) begin
            // Only (-0)+(-0) keeps the negative sign.
            res = {sa & sb, 31'd0};
        end else if (a_zero) begin
            res = b;
        end else if (b_zero) begin
            res = a;
        end else begin
            // Order by magnitude so the subtraction below never goes negative.
            if ({ea, fa} >= {eb, fb}) begin
                sl = sa; el = ea; ml = {1'b1, fa};
                ss = sb; es = eb; ms = {1'b1, fb};
            end else begin
                sl = sb; el = eb; ml = {1'b1, fb};
                ss = sa; es = ea; ms = {1'b1, fa};
            end
            diff   = el - es;
            // Three extra low bits: guard, round, sticky.
            ml_ext = {ml, 3'b000};
            ms_ext = {ms, 3'b000};
            if (diff >= 8'd26) begin
                // Smaller operand lies wholly below the round bit.
                ms_al = 27'd1;
            end else begin
                mask   = (27'd1 << diff) - 27'd1;
                sticky = |(ms_ext & mask);
                ms_al  = (ms_ext >> diff) | {26'd0, sticky};
            end

            if (sl == ss) begin
                sum = {1'b0, ml_ext} + {1'b0, ms_al};
            end else begin
                sum = {1'b0, ml_ext} - {1'b0, ms_al};
            end

            if (sum == 28'd0) begin
                res = 32'd0;
            end else begin
                if (sum[27]) begin
                    // Carry out: shift right one, folding the lost bit into sticky.
                    norm  = {sum[27:2], sum[1] | sum[0]};
                    exp_n = $signed({2'b00, el}) + 10'sd1;
                end else begin
                    lz    = lzc27(sum[26:0]);
                    norm  = sum[26:0] << lz;
                    exp_n = $signed({2'b00, el}) - $signed({5'd0, lz});
                end

`ifdef ACCUMULATE_RNE_EN
                inc = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
                inc = 1'b0;
`endif
                rnd = {1'b0, norm[26:3]} + {24'd0, inc};
                if (rnd[24]) begin
                    exp_n = exp_n + 10'sd1;
                    frac  = rnd[23:1];
                end else begin
                    frac  = rnd[22:0];
                end

                if (exp_n >= 10'sd255) begin
                    res = {sl, 8'hFF, 23'd0};
                end else if (exp_n <= 10'sd0) begin
                    res = 32'd0;
                end else begin
                    res = {sl, exp_n[7:0], frac};
                end
            end
        end
        return res;
    endfunction

    // Next accumulator value: start clears, valid adds, otherwise hold.
    always_comb begin
        acc_d  = acc_q;
        done_d = finished & ~start;
        if (start) begin
            acc_d = 32'd0;
        end else if (valid) begin
            acc_d = fp_add(acc_q, data);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and done registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= 32'd0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            done_q <= done_d;
        end
    end

    assign result = acc_q;
    assign done   = done_q;

endmodule

// File: tb/tb_accumulate.sv
// Testbench for accumulate: directed steps from the block's scenarios followed
// by randomized streams, checked against an exact-integer reference model.
// Honours ACCUMULATE_RNE_EN in the same way as the design.

module tb_accumulate;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        finished;
    logic [31:0] result;
    logic        done;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_acc;
    logic        m_done;

    always #5 clk = ~clk;

    accumulate dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .valid    (valid),
        .data     (data),
        .finished (finished),
        .result   (result),
        .done     (done)
    );

    // Exact value of a float as an integer multiple of 2^-149 (denormals -> 0).
    function automatic logic signed [319:0] to_int(input logic [31:0] f);
        logic signed [319:0] v;
        v = 320'sd0;
        if (f[30:23] != 8'd0) begin
            v[23:0] = {1'b1, f[22:0]};
            v = v << (int'(f[30:23]) - 1);
            if (f[31]) v = -v;
        end
        return v;
    endfunction

    // Reference add: exact integer sum, then a single rounding to binary32.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic                a_nan, b_nan, a_inf, b_inf, a_z, b_z;
        logic signed [319:0] s;
        logic [319:0]        mag, rem, half;
        logic [24:0]         mant;
        logic                sgn;
        int                  p, e, sh;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_z   = (a[30:23] == 8'h00);
        b_z   = (b[30:23] == 8'h00);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if (a_inf && b_inf) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a_z && b_z) return {a[31] & b[31], 31'd0};
        s = to_int(a) + to_int(b);
        if (s == 320'sd0) return 32'd0;
        sgn = (s < 320'sd0);
        mag = sgn ? 320'(-s) : 320'(s);
        p = 0;
        for (int i = 0; i < 320; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) return 32'd0;
        sh   = p - 23;
        mant = 25'(mag >> sh);
`ifdef ACCUMULATE_RNE_EN
        if (sh > 0) begin
            rem  = mag & ((320'd1 << sh) - 320'd1);
            half = 320'd1 << (sh - 1);
            if ((rem > half) || ((rem == half) && mant[0])) mant = mant + 25'd1;
        end
`endif
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        return {sgn, 8'(e), mant[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; model updated and outputs checked after the edge.
    task automatic step(input string tag, input logic st, input logic vl,
                        input logic [31:0] dt, input logic fn);
        start = st; valid = vl; data = dt; finished = fn;
        if (st)      m_acc = 32'd0;
        else if (vl) m_acc = ref_add(m_acc, dt);
        m_done = fn & ~st;
        @(posedge clk); #1;
        chk({tag, "_result"}, result, m_acc);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, m_done});
    endtask

    function automatic logic [31:0] rand_op();
        int          r;
        logic [31:0] v;
        r = $urandom_range(0, 15);
        if (r == 0) begin
            v = $urandom;
        end else if (r == 1) begin
            case ($urandom_range(0, 6))
                0: v = 32'h0000_0000;
                1: v = 32'h8000_0000;
                2: v = 32'h7F80_0000;
                3: v = 32'hFF80_0000;
                4: v = 32'h7FC0_0001;
                5: v = {1'b0, 8'd0, 23'(($urandom % 32'h7FFFFF) + 32'd1)};
                default: v = {1'b1, 8'hFE, 23'($urandom)};
            endcase
        end else begin
            v = {1'($urandom), 8'($urandom_range(118, 136)), 23'($urandom)};
        end
        return v;
    endfunction

    initial begin
        logic st, vl, fn;
        reset = 1'b1; start = 1'b0; valid = 1'b0; data = 32'd0; finished = 1'b0;
        m_acc = 32'd0; m_done = 1'b0;
        #12;
        chk("reset_result", result, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Scenario 1: four additions of 1.0
        step("s1_start", 1'b1, 1'b0, 32'd0, 1'b0);
        step("s1_a1", 1'b0, 1'b1, 32'h3F80_0000, 1'b0);
        chk("s1_k1", result, 32'h3F80_0000);
        step("s1_a2", 1'b0, 1'b1, 32'h3F80_0000, 1'b0);
        chk("s1_k2", result, 32'h4000_0000);
        step("s1_a3", 1'b0, 1'b1, 32'h3F80_0000, 1'b0);
        chk("s1_k3", result, 32'h4040_0000);
        step("s1_a4", 1'b0, 1'b1, 32'h3F80_0000, 1'b0);
        chk("s1_k4", result, 32'h4080_0000);

        // Scenario 2: gaps, then valid together with finished
        step("s2_g1", 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        step("s2_g2", 1'b0, 1'b0, 32'h3F80_0000, 1'b0);
        step("s2_g3", 1'b0, 1'b0, 32'd0, 1'b0);
        step("s2_a5", 1'b0, 1'b1, 32'h3F80_0000, 1'b0);
        step("s2_g4", 1'b0, 1'b0, 32'd0, 1'b0);
        step("s2_a6", 1'b0, 1'b1, 32'h3F80_0000, 1'b1);
        chk("s2_final", result, 32'h40C0_0000);
        chk("s2_done1", {31'd0, done}, 32'd1);
        step("s2_hold", 1'b0, 1'b0, 32'd0, 1'b0);
        chk("s2_done0", {31'd0, done}, 32'd0);
        chk("s2_holdv", result, 32'h40C0_0000);

        // finished held three cycles gives three done cycles; start masks done
        step("fin_h1", 1'b0, 1'b0, 32'd0, 1'b1);
        step("fin_h2", 1'b0, 1'b1, 32'h3F80_0000, 1'b1);
        step("fin_h3", 1'b0, 1'b0, 32'd0, 1'b1);
        step("fin_st", 1'b1, 1'b0, 32'd0, 1'b1);

        // Scenario 3: start beats valid
        step("s3_a", 1'b0, 1'b1, 32'h4000_0000, 1'b0);
        step("s3_start", 1'b1, 1'b1, 32'h4000_0000, 1'b0);
        chk("s3_zero", result, 32'd0);

        // Scenario 4: cancellation to +0, infinity, inf + -inf, sticky NaN
        step("s4_one", 1'b0, 1'b1, 32'h3F80_0000, 1'b0);
        step("s4_cancel", 1'b0, 1'b1, 32'hBF80_0000, 1'b0);
        chk("s4_pzero", result, 32'd0);
        step("s4_inf", 1'b0, 1'b1, 32'h7F80_0000, 1'b0);
        chk("s4_infv", result, 32'h7F80_0000);
        step("s4_nan", 1'b0, 1'b1, 32'hFF80_0000, 1'b0);
        chk("s4_nanv", result, 32'h7FC0_0000);
        step("s4_stay", 1'b0, 1'b1, 32'h3F80_0000, 1'b0);
        chk("s4_stayv", result, 32'h7FC0_0000);

        // Scenario 5: rounding at the guard bit
        step("s5_st1", 1'b1, 1'b0, 32'd0, 1'b0);
        step("s5_one", 1'b0, 1'b1, 32'h3F80_0000, 1'b0);
        step("s5_tie", 1'b0, 1'b1, 32'h3380_0000, 1'b0);
        chk("s5_tiev", result, 32'h3F80_0000);
        step("s5_st2", 1'b1, 1'b0, 32'd0, 1'b0);
        step("s5_one2", 1'b0, 1'b1, 32'h3F80_0000, 1'b0);
        step("s5_above", 1'b0, 1'b1, 32'h33C0_0000, 1'b0);
`ifdef ACCUMULATE_RNE_EN
        chk("s5_abovev", result, 32'h3F80_0001);
`else
        chk("s5_abovev", result, 32'h3F80_0000);
`endif
        step("s5_tie_odd", 1'b0, 1'b1, 32'h3380_0000, 1'b0);
        step("s5_ovf_st", 1'b1, 1'b0, 32'd0, 1'b0);
        step("s5_big", 1'b0, 1'b1, 32'h7F7F_FFFF, 1'b0);
        step("s5_ovf", 1'b0, 1'b1, 32'h7F7F_FFFF, 1'b0);
        chk("s5_ovfv", result, 32'h7F80_0000);

        // Scenario 6: reset between two valid cycles clears immediately
        step("s6_st", 1'b1, 1'b0, 32'd0, 1'b0);
        step("s6_a", 1'b0, 1'b1, 32'h4000_0000, 1'b1);
        valid = 1'b1; data = 32'h4000_0000; finished = 1'b1;
        reset = 1'b1;
        #2;
        chk("s6_async_result", result, 32'd0);
        chk("s6_async_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("s6_held_result", result, 32'd0);
        chk("s6_held_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        m_acc = 32'd0; m_done = 1'b0;
        step("s6_restart", 1'b1, 1'b0, 32'd0, 1'b0);

        // Randomized streams against the reference model
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 11) == 0);
            vl = ($urandom_range(0, 3) != 0);
            fn = ($urandom_range(0, 7) == 0);
            step("rnd", st, vl, rand_op(), fn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
